// File: rtl/saturation_timer_bank_pkg.sv
// Shared constants and helpers for the saturating phase-timer bank.
// Bound-select encodings and the per-channel operation decode live here.
package saturation_timer_bank_pkg;

  localparam logic CFG_FLOOR = 1'b0;
  localparam logic CFG_CEIL  = 1'b1;

  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_LOAD = 2'd1,
    OP_UP   = 2'd2,
    OP_DOWN = 2'd3
  } op_e;

  // Load beats stepping; a step needs the tick and exactly one direction.
  function automatic op_e op_decode(input logic load, input logic tick,
                                    input logic up, input logic down);
    op_e op;
    op = OP_HOLD;
    if (load)
      op = OP_LOAD;
    else if (tick && (up ^ down))
      op = up ? OP_UP : OP_DOWN;
    return op;
  endfunction

endpackage

// File: rtl/saturation_timer_channel.sv
// One saturating timer channel: count, floor/ceil bounds, clamp datapath and
// the registered expiry pulse.
module saturation_timer_channel
  import saturation_timer_bank_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_tick,
  input  logic             i_up,
  input  logic             i_down,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic [WIDTH-1:0] i_step,
  input  logic             i_cfg_we,
  input  logic             i_cfg_sel,
  input  logic [WIDTH-1:0] i_cfg_data,
  output logic [WIDTH-1:0] o_count,
  output logic             o_at_floor,
  output logic             o_at_ceil,
  output logic             o_expired,
  output logic             o_cfg_rej
);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_floor;
  logic [WIDTH-1:0] r_ceil;
  logic             r_expired;

  op_e              w_op;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_dn_limit;
  logic [WIDTH-1:0] w_up_sat;
  logic [WIDTH-1:0] w_up_res;
  logic [WIDTH-1:0] w_dn_raw;
  logic [WIDTH-1:0] w_dn_res;
  logic [WIDTH-1:0] w_load_res;
  logic [WIDTH-1:0] w_next;
  logic             w_expire;
  logic             w_cfg_ok;

  assign w_op = op_decode(i_load, i_tick, i_up, i_down);

  // Up path runs one bit wide so a carry-out saturates at the ceiling.
  assign w_sum    = {1'b0, r_count} + {1'b0, i_step};
  assign w_up_sat = (w_sum > {1'b0, r_ceil}) ? r_ceil : w_sum[WIDTH-1:0];
  assign w_up_res = (w_up_sat < r_floor) ? r_floor : w_up_sat;

  // Down path compares against floor+step instead of subtracting first.
  assign w_dn_limit = {1'b0, r_floor} + {1'b0, i_step};
  assign w_dn_raw   = ({1'b0, r_count} < w_dn_limit) ? r_floor : (r_count - i_step);
  assign w_dn_res   = (w_dn_raw > r_ceil) ? r_ceil : w_dn_raw;

  assign w_load_res = (i_load_val < r_floor) ? r_floor :
                      (i_load_val > r_ceil)  ? r_ceil  : i_load_val;

  always_comb begin
    w_next   = r_count;
    w_expire = 1'b0;
    case (w_op)
      OP_LOAD: w_next = w_load_res;
      OP_UP:   w_next = w_up_res;
      OP_DOWN: begin
        w_next   = w_dn_res;
        w_expire = (r_count != r_floor) && (w_dn_res == r_floor);
      end
      default: w_next = r_count;
    endcase
  end

  // A bound write is accepted only if it keeps floor <= ceil.
  assign w_cfg_ok  = (i_cfg_sel == CFG_FLOOR) ? (i_cfg_data <= r_ceil)
                                              : (r_floor <= i_cfg_data);
  assign o_cfg_rej = i_cfg_we && !w_cfg_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count   <= '1;
      r_floor   <= '0;
      r_ceil    <= '1;
      r_expired <= 1'b0;
    end else begin
      r_count   <= w_next;
      r_expired <= w_expire;
      if (i_cfg_we && w_cfg_ok) begin
        if (i_cfg_sel == CFG_FLOOR)
          r_floor <= i_cfg_data;
        else
          r_ceil  <= i_cfg_data;
      end
    end
  end

  assign o_count    = r_count;
  assign o_at_floor = (r_count == r_floor);
  assign o_at_ceil  = (r_count == r_ceil);
  assign o_expired  = r_expired;

endmodule

// File: rtl/saturation_timer_bank.sv
// Bank of independent saturating phase timers sharing one tick and step,
// with a single bound-write port and a registered reject pulse.
module saturation_timer_bank
  import saturation_timer_bank_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 5,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tick,
  input  logic [NUM_CH-1:0]       up,
  input  logic [NUM_CH-1:0]       down,
  input  logic [NUM_CH-1:0]       load,
  input  logic [NUM_CH*WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0]        step,
  input  logic                    cfg_we,
  input  logic [CH_W-1:0]         cfg_ch,
  input  logic                    cfg_sel,
  input  logic [WIDTH-1:0]        cfg_data,
  output logic [NUM_CH*WIDTH-1:0] count,
  output logic [NUM_CH-1:0]       at_floor,
  output logic [NUM_CH-1:0]       at_ceil,
  output logic [NUM_CH-1:0]       expired,
  output logic                    cfg_err
);

  logic [NUM_CH-1:0] w_ch_we;
  logic [NUM_CH-1:0] w_ch_rej;
  logic              w_oob;
  logic              r_cfg_err;

  // Addresses past the last channel cannot land anywhere and are rejected.
  assign w_oob = cfg_we && (int'(cfg_ch) >= NUM_CH);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign w_ch_we[g] = cfg_we && (int'(cfg_ch) == g);

    saturation_timer_channel #(
      .WIDTH (WIDTH)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .i_tick     (tick),
      .i_up       (up[g]),
      .i_down     (down[g]),
      .i_load     (load[g]),
      .i_load_val (load_val[g*WIDTH +: WIDTH]),
      .i_step     (step),
      .i_cfg_we   (w_ch_we[g]),
      .i_cfg_sel  (cfg_sel),
      .i_cfg_data (cfg_data),
      .o_count    (count[g*WIDTH +: WIDTH]),
      .o_at_floor (at_floor[g]),
      .o_at_ceil  (at_ceil[g]),
      .o_expired  (expired[g]),
      .o_cfg_rej  (w_ch_rej[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_cfg_err <= 1'b0;
    else
      r_cfg_err <= (|w_ch_rej) || w_oob;
  end

  assign cfg_err = r_cfg_err;

endmodule

// File: tb/tb_saturation_timer_bank.sv
// Bench for saturation_timer_bank: directed test-plan walk plus random
// traffic, checked against an integer reference model through a queue.
module tb_saturation_timer_bank;

  localparam int NCH = 4;
  localparam int W   = 5;
  localparam int CHW = 3;
  localparam int OBS = NCH*W + 3*NCH + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              tick;
  logic [NCH-1:0]    up, down, load;
  logic [NCH*W-1:0]  load_val;
  logic [W-1:0]      step;
  logic              cfg_we;
  logic [CHW-1:0]    cfg_ch;
  logic              cfg_sel;
  logic [W-1:0]      cfg_data;
  logic [NCH*W-1:0]  count;
  logic [NCH-1:0]    at_floor, at_ceil, expired;
  logic              cfg_err;

  logic [OBS-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int m_cnt[NCH];
  int m_flo[NCH];
  int m_cei[NCH];
  logic [NCH-1:0] m_exp;
  logic           m_err;

  saturation_timer_bank #(.NUM_CH(NCH), .WIDTH(W), .CH_W(CHW)) dut (
    .clk(clk), .rst(rst), .tick(tick), .up(up), .down(down), .load(load),
    .load_val(load_val), .step(step), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_sel(cfg_sel), .cfg_data(cfg_data), .count(count),
    .at_floor(at_floor), .at_ceil(at_ceil), .expired(expired), .cfg_err(cfg_err)
  );

  // clock
  always #5 clk = ~clk;

  function automatic logic [OBS-1:0] pack_model();
    logic [NCH*W-1:0] c;
    logic [NCH-1:0] af, ac;
    for (int i = 0; i < NCH; i++) begin
      c[i*W +: W] = W'(m_cnt[i]);
      af[i] = (m_cnt[i] == m_flo[i]);
      ac[i] = (m_cnt[i] == m_cei[i]);
    end
    return {c, af, ac, m_exp, m_err};
  endfunction

  task automatic model_step();
    int n, lv, st, ch, d;
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        m_cnt[i] = (1 << W) - 1;
        m_flo[i] = 0;
        m_cei[i] = (1 << W) - 1;
      end
      m_exp = '0;
      m_err = 1'b0;
    end else begin
      st = int'(step);
      for (int i = 0; i < NCH; i++) begin
        m_exp[i] = 1'b0;
        lv = int'(load_val[i*W +: W]);
        if (load[i]) begin
          m_cnt[i] = (lv < m_flo[i]) ? m_flo[i] : (lv > m_cei[i]) ? m_cei[i] : lv;
        end else if (tick && (up[i] != down[i])) begin
          n = up[i] ? m_cnt[i] + st : m_cnt[i] - st;
          if (n > m_cei[i]) n = m_cei[i];
          if (n < m_flo[i]) n = m_flo[i];
          m_exp[i] = down[i] && (m_cnt[i] != m_flo[i]) && (n == m_flo[i]);
          m_cnt[i] = n;
        end
      end
      m_err = 1'b0;
      if (cfg_we) begin
        ch = int'(cfg_ch);
        d  = int'(cfg_data);
        if (ch >= NCH) m_err = 1'b1;
        else if (cfg_sel == 1'b0) begin
          if (d <= m_cei[ch]) m_flo[ch] = d; else m_err = 1'b1;
        end else begin
          if (d >= m_flo[ch]) m_cei[ch] = d; else m_err = 1'b1;
        end
      end
    end
    exp_q.push_back(pack_model());
  endtask

  task automatic idle();
    rst = 1'b0; tick = 1'b0; up = '0; down = '0; load = '0; load_val = '0;
    step = '0; cfg_we = 1'b0; cfg_ch = '0; cfg_sel = 1'b0; cfg_data = '0;
  endtask

  // driver: predict, let one edge pass, return to idle inputs
  task automatic cycle();
    model_step();
    @(negedge clk);
    idle();
  endtask

  task automatic cfg_write(input int ch, input logic sel, input int data);
    cfg_we = 1'b1; cfg_ch = CHW'(ch); cfg_sel = sel; cfg_data = W'(data);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int cnt_of(input int i);
    return int'(count[i*W +: W]);
  endfunction

  // monitor: the DUT presents a new observation after every edge
  always @(posedge clk) begin
    logic [OBS-1:0] e, a;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {count, at_floor, at_ceil, expired, cfg_err};
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL obs: got cnt=%h af=%b ac=%b exp=%b err=%b expected cnt=%h af=%b ac=%b exp=%b err=%b",
                 a[OBS-1 -: NCH*W], a[3*NCH -: NCH], a[2*NCH -: NCH], a[NCH:1], a[0],
                 e[OBS-1 -: NCH*W], e[3*NCH -: NCH], e[2*NCH -: NCH], e[NCH:1], e[0]);
      end
    end
  end

  initial begin
    idle();
    rst = 1'b1;
    @(negedge clk);

    // reset
    rst = 1'b1; cycle();
    for (int i = 0; i < NCH; i++) chk("reset_count", cnt_of(i), 31);
    chk("reset_at_ceil", int'(at_ceil), 15);
    chk("reset_at_floor", int'(at_floor), 0);
    chk("reset_expired", int'(expired), 0);

    // down to floor
    cfg_write(0, 1'b0, 3); cycle();
    load[0] = 1'b1; load_val[0 +: W] = 5'd10; cycle();
    chk("dn_load", cnt_of(0), 10);
    down[0] = 1'b1; tick = 1'b1; step = 5'd4; cycle();
    chk("dn_6", cnt_of(0), 6);
    chk("dn_6_exp", int'(expired[0]), 0);
    down[0] = 1'b1; tick = 1'b1; step = 5'd4; cycle();
    chk("dn_3", cnt_of(0), 3);
    chk("dn_3_exp", int'(expired[0]), 1);
    down[0] = 1'b1; tick = 1'b1; step = 5'd4; cycle();
    chk("dn_hold", cnt_of(0), 3);
    chk("dn_hold_exp", int'(expired[0]), 0);

    // up saturation
    cfg_write(1, 1'b1, 20); cycle();
    load[1] = 1'b1; load_val[1*W +: W] = 5'd18; cycle();
    up[1] = 1'b1; tick = 1'b1; step = 5'd5; cycle();
    chk("up_sat", cnt_of(1), 20);
    chk("up_at_ceil", int'(at_ceil[1]), 1);
    up[2] = 1'b1; tick = 1'b1; step = 5'd31; cycle();
    chk("up_nowrap", cnt_of(2), 31);

    // gating and conflict
    up[0] = 1'b1; tick = 1'b0; step = 5'd2; cycle();
    chk("gate_tick0", cnt_of(0), 3);
    up[0] = 1'b1; down[0] = 1'b1; tick = 1'b1; step = 5'd2; cycle();
    chk("gate_conflict", cnt_of(0), 3);
    load[0] = 1'b1; load_val[0 +: W] = 5'd12; tick = 1'b0; cycle();
    chk("load_no_tick", cnt_of(0), 12);
    cfg_write(2, 1'b1, 25); cycle();
    load[2] = 1'b1; load_val[2*W +: W] = 5'd30; cycle();
    chk("load_clamp", cnt_of(2), 25);

    // config rejection
    cfg_write(3, 1'b1, 8); cycle();
    chk("cfg_ok", int'(cfg_err), 0);
    cfg_write(3, 1'b0, 12); cycle();
    chk("cfg_rej", int'(cfg_err), 1);
    chk("cfg_rej_floor", int'(at_floor[3]), 0);
    cycle();
    chk("cfg_err_pulse", int'(cfg_err), 0);
    cfg_write(4, 1'b0, 1); cycle();
    chk("cfg_oob", int'(cfg_err), 1);
    load[3] = 1'b1; load_val[3*W +: W] = 5'd6; cycle();
    chk("ch3_load", cnt_of(3), 6);
    cfg_write(3, 1'b0, 5); down[3] = 1'b1; tick = 1'b1; step = 5'd4; cycle();
    chk("old_bounds", cnt_of(3), 2);
    down[3] = 1'b1; tick = 1'b1; step = 5'd4; cycle();
    chk("new_floor", cnt_of(3), 5);
    chk("new_floor_exp", int'(expired[3]), 1);

    // reset mid-count
    down[0] = 1'b1; tick = 1'b1; step = 5'd1; cycle();
    chk("pre_rst", cnt_of(0), 11);
    rst = 1'b1; down = '1; tick = 1'b1; step = 5'd1; cycle();
    chk("mid_rst_count", cnt_of(0), 31);
    chk("mid_rst_exp", int'(expired), 0);

    // random traffic
    for (int k = 0; k < 600; k++) begin
      rst      = ($urandom_range(0, 99) == 0);
      tick     = ($urandom_range(0, 3) != 0);
      up       = NCH'($urandom);
      down     = NCH'($urandom);
      load     = NCH'($urandom & $urandom & $urandom);
      load_val = (NCH*W)'($urandom);
      step     = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 7));
      cfg_we   = ($urandom_range(0, 3) == 0);
      cfg_ch   = CHW'($urandom_range(0, NCH));
      cfg_sel  = 1'($urandom);
      cfg_data = W'($urandom);
      cycle();
    end

    repeat (2) cycle();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
